// File: rtl/mb_input_regs_stream.sv
// mb_input_regs_stream
//   AXI4-Lite slave holding a bank of NUM_CH per-frame input registers written
//   by the MicroBlaze. A commit snapshots the bank into one wide valid/ready
//   stream word for the draw pipeline. Accepted frames (stream handshakes) and
//   dropped commits are counted.
//
//   Register map (word index k = addr[ADDR_W-1:2]):
//     k <  NUM_CH    CH[k]   RW, byte strobes honoured
//     k == NUM_CH    CTRL    WO (reads 0): bit0 COMMIT, bit1 CLEAR counters
//     k == NUM_CH+1  STATUS  RO: bit0 m_valid, [31:16] DROP (saturating)
//     k == NUM_CH+2  FRAMES  RO: stream handshake count (wrapping)
//     other          SLVERR, writes ignored, reads return 0
//
//   Ports:
//     ACLK, ARESETN        clock, asynchronous active-low reset
//     s_axi_aw*/w*/b*      AXI4-Lite write channels
//     s_axi_ar*/r*         AXI4-Lite read channels
//     m_data               snapshot, channel i at [32i+31:32i]
//     m_valid, m_ready     stream handshake
//
//   Build option: define MB_INPUT_AUTOCOMMIT_EN so that any accepted write to
//   CH[NUM_CH-1] also commits (same drop/overlap rules, using the new value).
module mb_input_regs_stream #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CH             = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  output logic [NUM_CH*C_S_AXI_DATA_WIDTH-1:0] m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  localparam logic [31:0] IDX_CTRL   = 32'(NUM_CH);
  localparam logic [31:0] IDX_STATUS = 32'(NUM_CH + 1);
  localparam logic [31:0] IDX_FRAMES = 32'(NUM_CH + 2);
  localparam logic [31:0] IDX_LAST   = 32'(NUM_CH - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge a write beat into an existing word, lane by lane.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // DROP sticks at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DW-1:0] ch_q [NUM_CH];
  logic [DW-1:0] ch_d [NUM_CH];
  logic [15:0]   drop_q, drop_d;
  logic [31:0]   frames_q, frames_d;
  logic          m_valid_d;
  logic [NUM_CH*DW-1:0] m_data_d;

  logic [31:0]   wr_idx, rd_idx;
  logic          wr_fire, commit, clear, handshake;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_idx = 32'(s_axi_awaddr[AW-1:2]);
  assign rd_idx = 32'(s_axi_araddr[AW-1:2]);

  // awready is a one-cycle pulse raised only while both AW and W are valid;
  // the master must hold them through that cycle, so the pulse is the accept.
  assign wr_fire   = s_axi_awready;
  assign handshake = m_valid && m_ready;

  // Next state of the register bank, counters and stream word.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_d[i] = ch_q[i];
    commit = 1'b0;
    clear  = 1'b0;
    if (wr_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_idx == 32'(i)) ch_d[i] = apply_strb(ch_q[i], s_axi_wdata, s_axi_wstrb);
      end
      if (wr_idx == IDX_CTRL && s_axi_wstrb[0]) begin
        commit = s_axi_wdata[0];
        clear  = s_axi_wdata[1];
      end
`ifdef MB_INPUT_AUTOCOMMIT_EN
      if (wr_idx == IDX_LAST) commit = 1'b1;
`endif
    end

    // CLEAR acts before this cycle's increments so they survive it.
    drop_d    = clear ? 16'd0 : drop_q;
    frames_d  = clear ? 32'd0 : frames_q;
    m_valid_d = m_valid;
    m_data_d  = m_data;

    if (handshake) begin
      frames_d  = frames_d + 32'd1;
      m_valid_d = 1'b0;
    end

    // A commit loads whenever the slot is empty or is being emptied this cycle.
    if (commit) begin
      if (!m_valid || m_ready) begin
        m_valid_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) m_data_d[i*DW +: DW] = ch_d[i];
      end else begin
        drop_d = sat_inc16(drop_d);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      drop_q   <= '0;
      frames_q <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
      drop_q   <= drop_d;
      frames_q <= frames_d;
      m_valid  <= m_valid_d;
      m_data   <= m_data_d;
    end
  end

  // Write channel: accept pulse, then response held until bready.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      if (s_axi_awvalid && s_axi_wvalid && !s_axi_awready && !s_axi_bvalid) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_idx <= IDX_FRAMES) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read mux, sampled in the arready cycle.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_idx == 32'(i)) rd_data = ch_q[i];
    end
    if (rd_idx == IDX_STATUS) begin
      rd_data = {drop_q, 15'd0, m_valid};
    end else if (rd_idx == IDX_FRAMES) begin
      rd_data = frames_q;
    end else if (rd_idx > IDX_FRAMES) begin
      rd_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= 1'b0;
      if (s_axi_arvalid && !s_axi_arready && !s_axi_rvalid) s_axi_arready <= 1'b1;
      if (s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mb_input_regs_stream.sv
module tb_mb_input_regs_stream;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   s_axi_awaddr;
  logic         s_axi_awvalid, s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid, s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid, s_axi_bready;
  logic [5:0]   s_axi_araddr;
  logic         s_axi_arvalid, s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] m_data;
  logic         m_valid, m_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] sb_q[$];
  logic         mv_at_b;

  localparam logic [5:0] A_CTRL   = 6'd16;
  localparam logic [5:0] A_STATUS = 6'd20;
  localparam logic [5:0] A_FRAMES = 6'd24;
  localparam logic [5:0] A_UNMAP  = 6'd28;

  always #5 clk = ~clk;

  mb_input_regs_stream #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_CH(4)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic rdy, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 16) begin @(negedge clk); n++; end
    check_eq("aw_latency", n, 1);
    check_eq("w_ready", s_axi_wready, 1'b1);
    if (rdy) m_ready = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    if (rdy) m_ready = 1'b0;
    mv_at_b = m_valid;
    n = 0;
    while (!s_axi_bvalid && n < 16) begin @(negedge clk); n++; end
    check_eq("b_latency", n, 0);
    resp = s_axi_bresp;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 16) begin @(negedge clk); n++; end
    check_eq("ar_latency", n, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 16) begin @(negedge clk); n++; end
    check_eq("r_latency", n, 0);
    d = s_axi_rdata; resp = s_axi_rresp;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check_eq(tag, d, exp);
    check_eq({tag, "_rresp"}, r, 2'b00);
  endtask

  task automatic pulse_ready;
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
  endtask

  // Scoreboard: every stream handshake must match the oldest expected word.
  always @(negedge clk) begin
    #1;
    if (rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) check_eq("stream_expected", sb_q.size(), 1);
      else check_eq("stream_word", m_data, sb_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_data", m_data, 128'd0);
    check_eq("rst_awready", s_axi_awready, 1'b0);
    check_eq("rst_bvalid", s_axi_bvalid, 1'b0);
    check_eq("rst_arready", s_axi_arready, 1'b0);
    check_eq("rst_rvalid", s_axi_rvalid, 1'b0);
    check_eq("rst_rdata", s_axi_rdata, 32'd0);
    rst_n = 1'b1;

    read_expect("status_rst", A_STATUS, 32'd0);
    read_expect("frames_rst", A_FRAMES, 32'd0);
    read_expect("ch2_rst", 6'd8, 32'd0);

    for (int i = 0; i < 4; i++) begin
`ifdef MB_INPUT_AUTOCOMMIT_EN
      if (i == 3) sb_q.push_back(128'h00000004_00000003_00000002_00000001);
`endif
      axi_write(6'(4 * i), 32'(i + 1), 4'hF, 1'b0, resp);
      check_eq("ch_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) read_expect("ch_readback", 6'(4 * i), 32'(i + 1));

    axi_write(6'd4, 32'hAABBCCDD, 4'b0101, 1'b0, resp);
    read_expect("ch1_strobe", 6'd4, 32'h00BB00DD);
    axi_write(6'd5, 32'h00000002, 4'hF, 1'b0, resp);
    read_expect("ch1_restore_lsb_ignored", 6'd4, 32'h00000002);

`ifdef MB_INPUT_AUTOCOMMIT_EN
    pulse_ready();
    axi_write(A_CTRL, 32'h2, 4'hF, 1'b0, resp);
`endif

    // Overflow with m_ready low
    sb_q.push_back(128'h00000004_00000003_00000002_00000001);
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, resp);
    check_eq("commit_latency", mv_at_b, 1'b1);
    check_eq("commit_data", m_data, 128'h00000004_00000003_00000002_00000001);
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, resp);
    read_expect("status_drop1", A_STATUS, 32'h00010001);
    check_eq("data_held", m_data, 128'h00000004_00000003_00000002_00000001);
    pulse_ready();
    check_eq("valid_after_xfer", m_valid, 1'b0);
    read_expect("frames_1", A_FRAMES, 32'd1);

    // Commit coinciding with a transfer
    sb_q.push_back(128'h00000004_00000003_00000002_00000001);
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, resp);
    axi_write(6'd0, 32'h11, 4'hF, 1'b0, resp);
    check_eq("ch_write_no_stream", m_data, 128'h00000004_00000003_00000002_00000001);
    sb_q.push_back(128'h00000004_00000003_00000002_00000011);
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b1, resp);
    check_eq("overlap_valid", m_valid, 1'b1);
    check_eq("overlap_data", m_data, 128'h00000004_00000003_00000002_00000011);
    read_expect("overlap_status", A_STATUS, 32'h00010001);
    read_expect("overlap_frames", A_FRAMES, 32'd2);
    pulse_ready();
    read_expect("frames_3", A_FRAMES, 32'd3);

    // Unmapped address
    axi_write(A_UNMAP, 32'hDEADBEEF, 4'hF, 1'b0, resp);
    check_eq("unmap_bresp", resp, 2'b10);
    axi_read(A_UNMAP, d, resp);
    check_eq("unmap_rdata", d, 32'd0);
    check_eq("unmap_rresp", resp, 2'b10);
    read_expect("ch0_intact", 6'd0, 32'h11);
    read_expect("ctrl_reads0", A_CTRL, 32'd0);
    read_expect("frames_intact", A_FRAMES, 32'd3);

    // CLEAR and COMMIT together while the slot is full
    sb_q.push_back(128'h00000004_00000003_00000002_00000011);
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, resp);
    axi_write(A_CTRL, 32'h3, 4'hF, 1'b0, resp);
    read_expect("clr_status", A_STATUS, 32'h00010001);
    read_expect("clr_frames", A_FRAMES, 32'd0);
    pulse_ready();
    read_expect("clr_frames_after", A_FRAMES, 32'd1);
    read_expect("clr_status_after", A_STATUS, 32'h00010000);

    // Reset while m_valid=1 and bvalid=1
    axi_write(A_CTRL, 32'h1, 4'hF, 1'b0, resp);
    @(negedge clk);
    s_axi_awaddr = 6'd0; s_axi_wdata = 32'h9; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check_eq("pre_rst_bvalid", s_axi_bvalid, 1'b1);
    check_eq("pre_rst_mvalid", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_mvalid", m_valid, 1'b0);
    check_eq("mid_rst_mdata", m_data, 128'd0);
    check_eq("mid_rst_bvalid", s_axi_bvalid, 1'b0);
    check_eq("mid_rst_bresp", s_axi_bresp, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    read_expect("post_rst_ch0", 6'd0, 32'd0);
    read_expect("post_rst_status", A_STATUS, 32'd0);

`ifdef MB_INPUT_AUTOCOMMIT_EN
    sb_q.push_back(128'h00000007_00000000_00000000_00000000);
    axi_write(6'd12, 32'd7, 4'hF, 1'b0, resp);
    check_eq("auto_valid", m_valid, 1'b1);
    check_eq("auto_data", m_data[127:96], 32'd7);
    pulse_ready();
`else
    axi_write(6'd12, 32'd7, 4'hF, 1'b0, resp);
    check_eq("no_auto_valid", m_valid, 1'b0);
    read_expect("ch3_written", 6'd12, 32'd7);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mb_input_regs_stream.md
# mb_input_regs_stream

AXI4-Lite slave that receives per-frame input values written by the MicroBlaze into a parametrised bank of channel registers. On commit, it snapshots the bank into a single wide valid/ready stream word for the downstream draw pipeline. It also tracks accepted and dropped frames in counters. It sits between the processor AXI interconnect and the fabric datapath, and is the generalised successor of the fixed four-register input slave.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width and channel width (32 only; byte strobes assume 4 lanes)
- C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width; must cover 4*(NUM_CH+3) bytes
- NUM_CH, 4, number of channel registers, 1..12

- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- m_data  out  NUM_CH*32  snapshot; channel i occupies bits [32i+31:32i]
- m_valid / m_ready  out / in  1  stream handshake

## Operation
- **Address decode:** word index k = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored.
- **Register map:**
  - k < NUM_CH: CH[k], RW, with byte strobes honoured.
  - k = NUM_CH: CTRL, write-only (reads return 0).
    - bit0 COMMIT: write 1 to request a snapshot.
    - bit1 CLEAR: write 1 to zero both counters.
  - k = NUM_CH+1: STATUS, RO.
    - bit0 = m_valid.
    - [31:16] = DROP count, 16-bit, saturating at 0xFFFF.
  - k = NUM_CH+2: FRAMES, RO; 32-bit count of stream handshakes, wrapping.
  - Any other k: write ignored with bresp=SLVERR (2'b10); read returns rdata=0 with rresp=SLVERR. All mapped accesses return OKAY.
- **Commit:**
  - m_valid=0: load m_data from CH[] including the write of the same transaction, and set m_valid=1.
  - m_valid=1 and m_ready=0: m_data is unchanged and DROP increments.
  - m_valid=1 and m_ready=1 in the same cycle: the old word transfers, the new snapshot loads, m_valid stays 1, and DROP does not increment.
- **Stream:** each m_valid&&m_ready cycle increments FRAMES. m_data is stable while m_valid=1 and m_ready=0.
- **Simultaneous CLEAR and COMMIT** in one write: CLEAR takes effect first, so counters read 0 (+1 if the commit dropped or a handshake occurred that cycle).
- **Reset values:**
  - CH[], counters, m_data, m_valid: 0.
  - All AXI ready/valid outputs: 0.
  - bresp/rresp: 0; rdata: 0.
- **Reset asserted mid-operation:** outstanding AXI transactions and any pending snapshot are discarded.

## Timing
- **Write path:**
  - In cycle N, with awvalid&&wvalid&&!awready&&!bvalid: awready=wready=1 in N+1 (a single-cycle pulse).
  - The register update and bvalid=1 occur in N+2.
  - bvalid holds until bready; no new write is accepted while bvalid=1.
  - AW and W must both be valid before either is accepted.
- **Read path:**
  - In cycle N, with arvalid&&!arready&&!rvalid: arready pulses in N+1.
  - rvalid=1 with registered rdata in N+2; rvalid holds until rready.
  - Reads sample counters at the arready cycle.
- **Commit latency:** m_valid rises in the same cycle as the register update (write accept + 1).
- Reads and writes are independent and may overlap.

## Configuration
- **MB_INPUT_AUTOCOMMIT_EN**
  - Defined: any accepted write to CH[NUM_CH-1] also performs a commit, with identical drop/overlap rules, using the newly written value.
  - Undefined: commit occurs only via CTRL.COMMIT, and CH writes never touch the stream.

## Test plan
- **Reset defaults:** reset, then write CH0..CH3 = 1,2,3,4 and read back -> rdata 1,2,3,4 with rresp OKAY; STATUS=0, FRAMES=0.
- **Partial strobes:** write CH1=0xAABBCCDD with wstrb=4'b0101 over prior 0x00000002 -> CH1 reads 0x00BB00DD.
- **Overflow with m_ready=0:** COMMIT -> m_valid=1, m_data=0x00000004_00000003_00000002_00000001; a second COMMIT -> STATUS=0x00010001 with m_data unchanged; raise m_ready one cycle -> m_valid=0, FRAMES=1.
- **Concurrent commit and transfer:** commit in the same cycle as an m_valid&&m_ready handshake -> m_valid stays 1, m_data is the new snapshot, DROP is unchanged, FRAMES increments.
- **Unmapped address:** write/read at k=NUM_CH+3 -> bresp=2'b10 / rresp=2'b10, rdata=0, no register changes.
- **Reset mid-stream:** assert ARESETN low while m_valid=1 and bvalid=1 -> all outputs 0 immediately; with MB_INPUT_AUTOCOMMIT_EN defined, writing CH3=7 -> m_valid=1 with m_data[127:96]=7.
